// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter and the cache fill FSMs: state and owner
// encodings plus burst geometry.
package mem_arb_pkg;

  localparam int ARB_BURST_LEN = 8;
  localparam int ARB_MEM_LAT   = 4;
  localparam int ARB_OFF_W     = $clog2(ARB_BURST_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  function automatic owner_e state_owner(arb_state_e s);
    case (s)
      I_FILL:           state_owner = OWN_I;
      D_FILL, D_WRITE:  state_owner = OWN_D;
      default:          state_owner = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_burst_ctr.sv
// Issue and return counters for one fill burst. Both are cleared while the
// arbiter idles and run independently once a fill is granted.
module mem_burst_ctr #(
  parameter int BURST_LEN = 8,
  parameter int OFF_W     = $clog2(BURST_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             iss_i,
  input  logic             ret_i,
  output logic [OFF_W-1:0] iss_cnt_o,
  output logic             iss_busy_o,
  output logic [OFF_W-1:0] ret_cnt_o,
  output logic             ret_last_o
);

  localparam logic [OFF_W-1:0] LAST = OFF_W'(BURST_LEN - 1);

  logic [OFF_W-1:0] iss_cnt_q, iss_cnt_d;
  logic [OFF_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             iss_done_q, iss_done_d;

  always_comb begin
    iss_cnt_d  = iss_cnt_q;
    iss_done_d = iss_done_q;
    ret_cnt_d  = ret_cnt_q;
    if (clr_i) begin
      iss_cnt_d  = '0;
      iss_done_d = 1'b0;
      ret_cnt_d  = '0;
    end else begin
      // Issue stops after the last word; returns keep counting until done.
      if (iss_i && !iss_done_q) begin
        iss_cnt_d = iss_cnt_q + 1'b1;
        if (iss_cnt_q == LAST) iss_done_d = 1'b1;
      end
      if (ret_i) ret_cnt_d = ret_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_cnt_q  <= '0;
      iss_done_q <= 1'b0;
      ret_cnt_q  <= '0;
    end else begin
      iss_cnt_q  <= iss_cnt_d;
      iss_done_q <= iss_done_d;
      ret_cnt_q  <= ret_cnt_d;
    end
  end

  assign iss_cnt_o  = iss_cnt_q;
  assign iss_busy_o = ~iss_done_q;
  assign ret_cnt_o  = ret_cnt_q;
  assign ret_last_o = (ret_cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between I-cache fills and D-cache fills/stores.
// Define ARB_ROUND_ROBIN_EN to alternate the winner on simultaneous requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BURST_LEN = mem_arb_pkg::ARB_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_wait,
  output logic              ic_data_valid,
  output logic [2:0]        ic_word,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [15:0]       dc_wdata,
  output logic              dc_wait,
  output logic              dc_data_valid,
  output logic [2:0]        dc_word,
  output logic              dc_done,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_data_valid
);

  localparam int OFF_W  = $clog2(BURST_LEN);
  localparam int BASE_W = ADDR_W - OFF_W - 1;

  arb_state_e        state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              err_q, err_d;
  logic              pick_i;
  logic              ctr_clr, in_fill;
  logic [OFF_W-1:0]  iss_cnt, ret_cnt;
  logic              iss_busy, ret_last;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q, last_d;

  // Reset value OWN_NONE lets I win the first tie.
  assign pick_i = ic_req & (~dc_req | (last_q != OWN_I));

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE) begin
      if (pick_i)      last_d = OWN_I;
      else if (dc_req) last_d = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWN_NONE;
    else        last_q <= last_d;
  end
`else
  assign pick_i = ic_req;
`endif

  assign in_fill = (state_q == I_FILL) || (state_q == D_FILL);
  assign ctr_clr = (state_q == IDLE);

  mem_burst_ctr #(.BURST_LEN(BURST_LEN)) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (ctr_clr),
    .iss_i      (in_fill),
    .ret_i      (in_fill & mem_data_valid),
    .iss_cnt_o  (iss_cnt),
    .iss_busy_o (iss_busy),
    .ret_cnt_o  (ret_cnt),
    .ret_last_o (ret_last)
  );

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    err_d         = err_q;
    ic_wait       = (state_owner(state_q) == OWN_D);
    dc_wait       = (state_owner(state_q) == OWN_I);
    ic_data_valid = 1'b0;
    ic_word       = '0;
    ic_done       = 1'b0;
    dc_data_valid = 1'b0;
    dc_word       = '0;
    dc_done       = 1'b0;
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_q)
      IDLE: begin
        dc_wait = ic_req & dc_req;
        if (mem_data_valid) err_d = 1'b1;
        // Line base is captured once here and held for the whole burst.
        if (pick_i) begin
          state_d = I_FILL;
          base_d  = ic_addr[ADDR_W-1:OFF_W+1];
        end else if (dc_req) begin
          state_d = dc_wr ? D_WRITE : D_FILL;
          base_d  = dc_addr[ADDR_W-1:OFF_W+1];
        end
      end
      I_FILL: begin
        mem_enable    = iss_busy;
        mem_addr      = {base_q, iss_cnt, 1'b0};
        ic_data_valid = mem_data_valid;
        ic_word       = 3'(ret_cnt);
        if (mem_data_valid && ret_last) begin
          ic_done = 1'b1;
          state_d = IDLE;
        end
      end
      D_FILL: begin
        mem_enable    = iss_busy;
        mem_addr      = {base_q, iss_cnt, 1'b0};
        dc_data_valid = mem_data_valid;
        dc_word       = 3'(ret_cnt);
        if (mem_data_valid && ret_last) begin
          dc_done = 1'b1;
          state_d = IDLE;
        end
      end
      D_WRITE: begin
        if (mem_data_valid) err_d = 1'b1;
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = dc_addr;
        mem_wdata  = dc_wdata;
        dc_done    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: delayed-return memory model plus a transaction-level
// timeline model of grants, issued addresses, returns, done pulses and waits.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int BL  = ARB_BURST_LEN;
  localparam int LAT = ARB_MEM_LAT;

  typedef logic [63:0] q64_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_req = 1'b0, dc_req = 1'b0, dc_wr = 1'b0;
  logic [15:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0;
  logic        ic_wait, ic_data_valid, ic_done, dc_wait, dc_data_valid, dc_done;
  logic [2:0]  ic_word, dc_word;
  logic        mem_enable, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata;
  logic [LAT-1:0] rd_pipe = '0;
  logic        inject = 1'b0;

  int passed = 0, total = 0, fails = 0;
  bit last_d = 1'b1;

  q64_t obs_mem, exp_mem, obs_icv, exp_icv, obs_dcv, exp_dcv;
  q64_t obs_icd, exp_icd, obs_dcd, exp_dcd;
  logic [63:0] obs_icw, exp_icw, obs_dcw, exp_dcw;

  mem_arbiter #(.ADDR_W(16), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_wait(ic_wait),
    .ic_data_valid(ic_data_valid), .ic_word(ic_word), .ic_done(ic_done),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wait(dc_wait), .dc_data_valid(dc_data_valid), .dc_word(dc_word), .dc_done(dc_done),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  // Memory: each read issued in cycle t returns valid in cycle t+LAT.
  always @(posedge clk) rd_pipe <= {rd_pipe[LAT-2:0], mem_enable & ~mem_wr};
  assign mem_data_valid = rd_pipe[LAT-1] | inject;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_q(input string nm, input q64_t o, input q64_t x);
    chk({nm, "_count"}, 64'(o.size()), 64'(x.size()));
    for (int i = 0; i < o.size() && i < x.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), o[i], x[i]);
  endtask

  task automatic clear_q();
    obs_mem.delete(); exp_mem.delete(); obs_icv.delete(); exp_icv.delete();
    obs_dcv.delete(); exp_dcv.delete(); obs_icd.delete(); exp_icd.delete();
    obs_dcd.delete(); exp_dcd.delete();
    obs_icw = '0; exp_icw = '0; obs_dcw = '0; exp_dcw = '0;
  endtask

  task automatic sample(input int k);
    if (mem_enable)
      obs_mem.push_back({16'(k), 15'd0, mem_wr, mem_addr, mem_wr ? mem_wdata : 16'h0});
    if (ic_data_valid) obs_icv.push_back({16'(k), 45'd0, ic_word});
    if (dc_data_valid) obs_dcv.push_back({16'(k), 45'd0, dc_word});
    if (ic_done) obs_icd.push_back(64'(k));
    if (dc_done) obs_dcd.push_back(64'(k));
    if (k < 64) begin
      obs_icw[k] = ic_wait;
      obs_dcw[k] = dc_wait;
    end
  endtask

  // Expected footprint of one grant whose first owned cycle is s.
  task automatic add_grant(input bit is_i, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wd, input int s, output int e);
    logic [15:0] base;
    base = {addr[15:4], 4'h0};
    if (wr) begin
      exp_mem.push_back({16'(s), 15'd0, 1'b1, addr, wd});
      exp_dcd.push_back(64'(s));
      exp_icw[s] = 1'b1;
      e = s;
    end else begin
      for (int j = 0; j < BL; j++) begin
        exp_mem.push_back({16'(s + j), 15'd0, 1'b0, base + 16'(2 * j), 16'h0});
        if (is_i) exp_icv.push_back({16'(s + LAT + j), 45'd0, 3'(j)});
        else      exp_dcv.push_back({16'(s + LAT + j), 45'd0, 3'(j)});
      end
      e = s + BL + LAT - 1;
      if (is_i) exp_icd.push_back(64'(e));
      else      exp_dcd.push_back(64'(e));
      for (int c = s; c <= e; c++) begin
        if (is_i) exp_dcw[c] = 1'b1;
        else      exp_icw[c] = 1'b1;
      end
    end
    last_d = !is_i;
  endtask

  // raise_at<0: D requests together with I; otherwise D rises after cycle raise_at.
  task automatic run_case(input string nm, input bit ien, input bit den, input bit dwr,
                          input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd,
                          input int raise_at, input int drop_at);
    int e1, e2, ncyc;
    bit i_first, tie;
    clear_q();
    tie = ien && den && (raise_at < 0);
    i_first = ien;
`ifdef ARB_ROUND_ROBIN_EN
    if (tie) i_first = last_d;
`endif
    e1 = 0;
    e2 = 0;
    if (i_first) add_grant(1'b1, 1'b0, ia, 16'h0, 0, e1);
    else         add_grant(1'b0, dwr, da, wd, 0, e1);
    if (ien && den) begin
      if (i_first) add_grant(1'b0, dwr, da, wd, e1 + 2, e2);
      else         add_grant(1'b1, 1'b0, ia, 16'h0, e1 + 2, e2);
    end else begin
      e2 = e1;
    end
    ncyc = e2 + 3;

    @(negedge clk);
    ic_addr = ia; dc_addr = da; dc_wdata = wd; dc_wr = dwr;
    ic_req = ien;
    dc_req = den && (raise_at < 0);
    #1 chk({nm, ":idle_dc_wait"}, 64'(dc_wait), 64'(tie));
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      sample(k);
      if (ic_done || k == drop_at) ic_req = 1'b0;
      if (dc_done) dc_req = 1'b0;
      if (den && k == raise_at) dc_req = 1'b1;
    end
    cmp_q({nm, ":mem"}, obs_mem, exp_mem);
    cmp_q({nm, ":ic_valid"}, obs_icv, exp_icv);
    cmp_q({nm, ":dc_valid"}, obs_dcv, exp_dcv);
    cmp_q({nm, ":ic_done"}, obs_icd, exp_icd);
    cmp_q({nm, ":dc_done"}, obs_dcd, exp_dcd);
    chk({nm, ":ic_wait"}, obs_icw, exp_icw);
    chk({nm, ":dc_wait"}, obs_dcw, exp_dcw);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ic_wait, ic_data_valid, ic_word, ic_done, dc_wait, dc_data_valid, dc_word,
                dc_done, mem_enable, mem_wr, mem_addr, mem_wdata});
  endfunction

  initial begin
    int nvalid;
    #1 chk("reset_outputs", all_outs(), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_case("ifill_1234", 1, 0, 0, 16'h1234, 16'h0, 16'h0, -1, -1);
    run_case("tie_40_80", 1, 1, 0, 16'h0040, 16'h0080, 16'h0, -1, -1);
    run_case("dwrite_a6", 0, 1, 1, 16'h0, 16'h00A6, 16'hBEEF, -1, -1);
    run_case("no_preempt", 1, 1, 0, 16'h5550, 16'h6662, 16'h0, 3, -1);
    run_case("ic_drop", 1, 0, 0, 16'h7776, 16'h0, 16'h0, -1, 2);

    // Stray return while idle must not reach either cache.
    @(negedge clk);
    inject = 1'b1;
    #1 chk("stray_valid_idle", 64'({ic_data_valid, dc_data_valid, ic_done, dc_done}), 64'h0);
    @(negedge clk);
    inject = 1'b0;

    // Reset in the middle of an I fill, at return word 5.
    clear_q();
    @(negedge clk);
    ic_addr = 16'h3456; ic_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      sample(k);
    end
    chk("rst_at_word5", 64'({ic_data_valid, ic_word}), 64'({1'b1, 3'd5}));
    rst_n = 1'b0;
    ic_req = 1'b0;
    #1 chk("rst_async_outputs", all_outs(), 64'h0);
    clear_q();
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_data_valid) nvalid++;
      sample(k);
      if (k == 0) rst_n = 1'b1;
    end
    last_d = 1'b1;
    chk("rst_late_returns_seen", 64'(nvalid), 64'd2);
    chk("rst_no_ic_valid", 64'(obs_icv.size()), 64'd0);
    chk("rst_no_mem_issue", 64'(obs_mem.size()), 64'd0);
    run_case("after_rst", 1, 0, 0, 16'h3456, 16'h0, 16'h0, -1, -1);

    for (int n = 0; n < 20; n++) begin
      int typ, raise, drop;
      logic [15:0] ia, da, wd;
      typ = $urandom_range(0, 4);
      ia = 16'($urandom);
      da = 16'($urandom);
      wd = 16'($urandom);
      raise = $urandom_range(0, 8);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : -1;
      case (typ)
        0: run_case($sformatf("rnd%0d_i", n), 1, 0, 0, ia, da, wd, -1, drop);
        1: run_case($sformatf("rnd%0d_dfill", n), 0, 1, 0, ia, da, wd, -1, -1);
        2: run_case($sformatf("rnd%0d_dwr", n), 0, 1, 1, ia, da, wd, -1, -1);
        3: run_case($sformatf("rnd%0d_tie", n), 1, 1, 1'($urandom_range(0, 1)), ia, da, wd, -1, -1);
        default: run_case($sformatf("rnd%0d_late", n), 1, 1, 1'($urandom_range(0, 1)), ia, da, wd, raise, drop);
      endcase
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates single-ported main memory between the I-cache fill FSM and the D-cache (fill reads and write-through stores).
- Sits directly upstream of both cache fill FSMs.
- Issues the 8-word burst read addresses for a granted fill and produces the per-requester memory_data_valid, word index and wait/arbitration signals each fill FSM consumes.
- Memory read data is broadcast outside this block. Only control is routed here.

Parameters:
ADDR_W, 16, address width
BURST_LEN, 8, 16-bit words per cache line (power of 2)
MEM_LAT, 4, cycles from read issue to mem_data_valid for that word

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ic_req  in  1  I-cache fill request, level, held until ic_done
ic_addr  in  ADDR_W  I-cache miss address
ic_wait  out  1  I-cache must hold off (memory owned by D side)
ic_data_valid  out  1  fill word valid for I-cache
ic_word  out  3  index of the word currently valid for I-cache
ic_done  out  1  one-cycle pulse, last I-cache fill word returned
dc_req  in  1  D-cache request, level
dc_wr  in  1  with dc_req: 1=single-word write, 0=line fill
dc_addr  in  ADDR_W  D-cache address
dc_wdata  in  16  write data
dc_wait  out  1  D-cache must hold off (memory owned by I side)
dc_data_valid  out  1  fill word valid for D-cache
dc_word  out  3  word index for D-cache
dc_done  out  1  one-cycle pulse, fill complete or write accepted
mem_enable  out  1  memory access this cycle
mem_wr  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  16  memory write data
mem_data_valid  in  1  memory read data valid

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, priority pointer = I.
- States:
  - IDLE: choose the next owner.
  - I_FILL: issue I-cache burst and collect returns.
  - D_FILL: issue D-cache burst and collect returns.
  - D_WRITE: one-cycle write.
- Grant selection in IDLE (evaluated every cycle):
  - Fixed priority: I over D.
  - ic_req -> I_FILL next cycle.
  - else dc_req & dc_wr -> D_WRITE.
  - else dc_req -> D_FILL.
  - No request -> stay in IDLE.
- Grant is locked until its done pulse. Requests arriving mid-burst never preempt.
- Fill burst issue:
  - Issue counter ic_cnt runs 0..BURST_LEN-1.
  - Each cycle: mem_enable=1, mem_wr=0, mem_addr = {addr[ADDR_W-1:4], ic_cnt, 1'b0}.
  - The line base is latched at grant and is not re-sampled.
- Return tracking:
  - Return counter rc_cnt increments on each mem_data_valid while in a fill state.
  - Owner's data_valid = mem_data_valid; owner's word = rc_cnt[2:0].
  - On the BURST_LEN-th valid, done pulses and the state goes to IDLE next cycle.
  - Issue and return are independent; up to MEM_LAT reads are outstanding.
  - Total burst latency = BURST_LEN+MEM_LAT-1 cycles from the first issue.
- mem_data_valid in IDLE or D_WRITE: ignored, no data_valid asserted, sticky internal error flag set.
- D_WRITE:
  - Single cycle: mem_enable=1, mem_wr=1, mem_addr=dc_addr, mem_wdata=dc_wdata.
  - dc_done=1 in the same cycle; then IDLE.
- Wait signals:
  - ic_wait=1 while state is D_FILL or D_WRITE.
  - dc_wait=1 while state is I_FILL, and also in IDLE when ic_req and dc_req are both 1.
- Back-to-back requests: the grant for the next request is decided in the IDLE cycle after done, giving one bubble cycle between bursts.
- Requester dropping req mid-burst: the burst completes regardless; done still pulses.
- rst_n low mid-burst: immediate return to IDLE. Outstanding memory returns after reset are ignored per the IDLE rule.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - On simultaneous ic_req and dc_req in IDLE, the winner is the side that did not own the most recent grant.
  - Pointer flips on every grant; reset pointer favours I.
- Undefined: fixed I-over-D priority as above.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, I_FILL, D_FILL, D_WRITE)
  - BURST_LEN, MEM_LAT, word-offset width constant
  - owner encoding, also used by the fill FSMs
- Natural sub-module: mem_burst_ctr (issue and return counters with terminal-count flags), instantiated once.

Test Plan:
- ic_req=1, ic_addr=0x1234 -> mem_addr 0x1230,0x1232..0x123E on 8 consecutive cycles; ic_data_valid 8 times with ic_word 0..7; ic_done pulses on the 8th; dc_wait high throughout.
- ic_req and dc_req (fill) rise together at 0x0040/0x0080 -> I burst first; D burst starts after one IDLE bubble; ic_wait high during the D burst. With ARB_ROUND_ROBIN_EN and last owner I -> D first.
- dc_req=1, dc_wr=1, dc_addr=0x00A6, dc_wdata=0xBEEF -> one cycle with mem_wr=1, mem_addr=0x00A6, mem_wdata=0xBEEF, dc_done=1; back to IDLE.
- dc_req asserted at I burst cycle 3 -> no preemption; D granted only after ic_done.
- rst_n pulled low at return word 5 of an I fill -> outputs 0 asynchronously; later mem_data_valid pulses produce no ic_data_valid; next ic_req restarts at word 0.
- ic_req dropped at cycle 2 of a burst -> all 8 words still issued and returned; ic_done pulses.
